// File: rtl/core_seq.sv
// ---------------------------------------------------------------------------
// core_seq -- multi-cycle instruction sequencer for a small register machine.
//
// Walks each instruction through FETCH -> DECODE -> EXECUTE -> SAVE, with a
// MEMWAIT detour for LOAD/STORE. The decoder and ALU sit outside this block;
// it owns the register file (including sp and ip), the flags, and the
// memory handshake.
//
// Optional feature: define CORE_SEQ_STACK_CHECK_EN to enable stack bounds
// checking on sp. This adds the stack_lo/stack_hi/stack_exc registers,
// loaded by op_kind 10/11/12, and the stack_fault output.
//
// Parameters
//   WIDTH       data/register/address width (even, >= 16)
//   REGS_CODING register index width; top index = ip, top-1 = sp
//   FLAGS       flag count {CF,SF,OF,ZF} at bits 0..3
//   RESET_IP    ip value after reset and after HALT
//
// Ports
//   clk, reset          clock (rising edge), async active-high reset
//   instruction         instruction word at instr_addr (bit WIDTH-1 = long)
//   instr_addr          current ip
//   instr_half          0 = upper half current, 1 = lower half current
//   op_kind, op1, op2   decoded class and destination/source indices
//   imm                 half-word immediate for MOVL/MOVH
//   cond_ok             condition result; 0 turns the op into a NOP
//   operand1/operand2   combinational reads of reg[op1]/reg[op2]
//   alu_result/flags    external ALU outputs
//   flags               architectural flags
//   mem_*               memory request/response handshake
//   interrupt_start     wakes the core from IDLE
//   interrupt_finish    one-cycle pulse after HALT
//   stack_fault         one-cycle pulse on a rejected sp write (feature only)
//   busy                high in every state except IDLE
// ---------------------------------------------------------------------------
module core_seq #(
    parameter int               WIDTH       = 32,
    parameter int               REGS_CODING = 3,
    parameter int               FLAGS       = 4,
    parameter logic [WIDTH-1:0] RESET_IP    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       instruction,
    output logic [WIDTH-1:0]       instr_addr,
    output logic                   instr_half,
    input  logic [3:0]             op_kind,
    input  logic [REGS_CODING-1:0] op1,
    input  logic [REGS_CODING-1:0] op2,
    input  logic [WIDTH/2-1:0]     imm,
    input  logic                   cond_ok,
    output logic [WIDTH-1:0]       operand1,
    output logic [WIDTH-1:0]       operand2,
    input  logic [WIDTH-1:0]       alu_result,
    input  logic [FLAGS-1:0]       alu_flags,
    output logic [FLAGS-1:0]       flags,
    output logic                   mem_request,
    output logic                   mem_wren,
    output logic [WIDTH-1:0]       mem_address,
    output logic [WIDTH-1:0]       mem_writedata,
    input  logic [WIDTH-1:0]       mem_readdata,
    input  logic                   mem_response,
    input  logic                   interrupt_start,
    output logic                   interrupt_finish,
`ifdef CORE_SEQ_STACK_CHECK_EN
    output logic                   stack_fault,
`endif
    output logic                   busy
);

    localparam int                     NREGS  = 2 ** REGS_CODING;
    localparam int                     HW     = WIDTH / 2;
    localparam logic [REGS_CODING-1:0] IP_IDX = '1;
    localparam logic [REGS_CODING-1:0] SP_IDX = {{(REGS_CODING-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0]       ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [3:0] OP_ALU   = 4'd1;
    localparam logic [3:0] OP_MOV   = 4'd2;
    localparam logic [3:0] OP_MOVL  = 4'd3;
    localparam logic [3:0] OP_MOVH  = 4'd4;
    localparam logic [3:0] OP_MOVF  = 4'd5;
    localparam logic [3:0] OP_JMP   = 4'd6;
    localparam logic [3:0] OP_LOAD  = 4'd7;
    localparam logic [3:0] OP_STORE = 4'd8;
    localparam logic [3:0] OP_HALT  = 4'd9;
`ifdef CORE_SEQ_STACK_CHECK_EN
    localparam logic [3:0] OP_SLO   = 4'd10;
    localparam logic [3:0] OP_SHI   = 4'd11;
    localparam logic [3:0] OP_SEXC  = 4'd12;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_SAVE,
        S_MEMWAIT
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]       regs [NREGS];
    logic [WIDTH-1:0]       result_q;
    logic                   mem_is_load;
    logic [REGS_CODING-1:0] mem_dst;

    // Control decoded from the current state and op
    logic                   latch_alu;
    logic                   wr_en;
    logic [REGS_CODING-1:0] wr_idx;
    logic [WIDTH-1:0]       wr_data;
    logic                   advance;
    logic                   mem_start;
    logic                   mem_done;
    logic                   halt;
    logic                   sp_fault;
    logic [WIDTH:0]         seq_next;

    // Only the long-instruction bit of the word matters here
    logic unused_instr;
    assign unused_instr = ^instruction[WIDTH-2:0];

`ifdef CORE_SEQ_STACK_CHECK_EN
    logic [WIDTH-1:0] stack_lo;
    logic [WIDTH-1:0] stack_hi;
    logic [WIDTH-1:0] stack_exc;
    logic             ld_slo;
    logic             ld_shi;
    logic             ld_sexc;
`endif

    // Sequential advance: {instr_half_next, ip_next}. A long instruction or
    // the lower half of a packed word moves to the next word.
    function automatic logic [WIDTH:0] seq_advance(input logic [WIDTH-1:0] ip,
                                                   input logic             half,
                                                   input logic             long_instr);
        if (long_instr || half)
            return {1'b0, ip + ONE};
        else
            return {1'b1, ip};
    endfunction

    assign instr_addr = regs[IP_IDX];
    assign operand1   = regs[op1];
    assign operand2   = regs[op2];
    assign busy       = (state != S_IDLE);
    assign seq_next   = seq_advance(regs[IP_IDX], instr_half, instruction[WIDTH-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (interrupt_start) state_next = S_FETCH;
            S_FETCH:   state_next = S_DECODE;
            S_DECODE:  state_next = S_EXECUTE;
            S_EXECUTE: state_next = S_SAVE;
            S_SAVE: begin
                if (halt)
                    state_next = S_IDLE;
                else if (mem_start)
                    state_next = S_MEMWAIT;
                else
                    state_next = S_FETCH;
            end
            S_MEMWAIT: if (mem_response) state_next = S_FETCH;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        latch_alu = (state == S_EXECUTE) && cond_ok && (op_kind == OP_ALU);
        wr_en     = 1'b0;
        wr_idx    = op1;
        wr_data   = '0;
        advance   = 1'b0;
        mem_start = 1'b0;
        mem_done  = 1'b0;
        halt      = 1'b0;
`ifdef CORE_SEQ_STACK_CHECK_EN
        ld_slo    = 1'b0;
        ld_shi    = 1'b0;
        ld_sexc   = 1'b0;
`endif
        if (state == S_SAVE) begin
            advance = 1'b1;
            if (cond_ok) begin
                case (op_kind)
                    OP_ALU: begin
                        wr_en   = 1'b1;
                        wr_data = result_q;
                    end
                    OP_MOV: begin
                        wr_en   = 1'b1;
                        wr_data = operand2;
                    end
                    OP_MOVL: begin
                        wr_en   = 1'b1;
                        wr_data = {operand1[WIDTH-1:HW], imm};
                    end
                    OP_MOVH: begin
                        wr_en   = 1'b1;
                        wr_data = {imm, operand1[HW-1:0]};
                    end
                    OP_MOVF: begin
                        wr_en   = 1'b1;
                        wr_data = WIDTH'(flags);
                    end
                    OP_JMP: begin
                        wr_en   = 1'b1;
                        wr_idx  = IP_IDX;
                        wr_data = operand1;
                    end
                    OP_LOAD, OP_STORE: begin
                        mem_start = 1'b1;
                        advance   = 1'b0;
                    end
                    OP_HALT: begin
                        halt    = 1'b1;
                        advance = 1'b0;
                    end
`ifdef CORE_SEQ_STACK_CHECK_EN
                    OP_SLO:  ld_slo  = 1'b1;
                    OP_SHI:  ld_shi  = 1'b1;
                    OP_SEXC: ld_sexc = 1'b1;
`endif
                    default: ;
                endcase
            end
        end else if (state == S_MEMWAIT && mem_response) begin
            // Completion: the request was issued at least one cycle ago
            mem_done = 1'b1;
            advance  = 1'b1;
            if (mem_is_load) begin
                wr_en   = 1'b1;
                wr_idx  = mem_dst;
                wr_data = mem_readdata;
            end
        end
    end

`ifdef CORE_SEQ_STACK_CHECK_EN
    assign sp_fault = wr_en && (wr_idx == SP_IDX) &&
                      ((wr_data < stack_lo) || (wr_data > stack_hi));
`else
    assign sp_fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            regs[IP_IDX]     <= RESET_IP;
            instr_half       <= 1'b0;
            flags            <= '0;
            result_q         <= '0;
            mem_request      <= 1'b0;
            mem_wren         <= 1'b0;
            mem_address      <= '0;
            mem_writedata    <= '0;
            mem_is_load      <= 1'b0;
            mem_dst          <= '0;
            interrupt_finish <= 1'b0;
`ifdef CORE_SEQ_STACK_CHECK_EN
            stack_lo         <= '0;
            stack_hi         <= '1;
            stack_exc        <= '0;
            stack_fault      <= 1'b0;
`endif
        end else begin
            interrupt_finish <= 1'b0;
`ifdef CORE_SEQ_STACK_CHECK_EN
            stack_fault      <= 1'b0;
            if (ld_slo)  stack_lo  <= operand1;
            if (ld_shi)  stack_hi  <= operand1;
            if (ld_sexc) stack_exc <= operand1;
`endif
            if (latch_alu) begin
                result_q <= alu_result;
                flags    <= alu_flags;
            end

            // Memory side: everything stays frozen while the request is open
            if (mem_start) begin
                mem_request <= 1'b1;
                mem_wren    <= (op_kind == OP_STORE);
                mem_address <= operand2;
                if (op_kind == OP_STORE)
                    mem_writedata <= operand1;
                mem_is_load <= (op_kind == OP_LOAD);
                mem_dst     <= op1;
            end else if (mem_done) begin
                mem_request <= 1'b0;
            end

            // Register file / ip update; an ip write (or stack redirect)
            // replaces the sequential advance
            if (halt) begin
                for (int i = 0; i < NREGS; i++)
                    regs[i] <= '0;
                regs[IP_IDX]     <= RESET_IP;
                instr_half       <= 1'b0;
                interrupt_finish <= 1'b1;
            end else if (sp_fault) begin
`ifdef CORE_SEQ_STACK_CHECK_EN
                regs[IP_IDX] <= stack_exc;
                stack_fault  <= 1'b1;
`endif
                instr_half   <= 1'b0;
            end else if (wr_en && wr_idx == IP_IDX) begin
                regs[IP_IDX] <= wr_data;
                instr_half   <= 1'b0;
            end else begin
                if (wr_en)
                    regs[wr_idx] <= wr_data;
                if (advance) begin
                    regs[IP_IDX] <= seq_next[WIDTH-1:0];
                    instr_half   <= seq_next[WIDTH];
                end
            end
        end
    end

endmodule
